// File: rtl/dmem_responder.sv
// dmem_responder
// Memory-side responder for CPU load/store requests. A request is accepted on
// a valid/ready handshake while idle, optional wait states are inserted, and
// the access is then performed in one word beat, or two beats when it crosses
// a word boundary. Load data is sign- or zero-extended and returned with a
// single-cycle completion pulse. Stores also complete with a pulse.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   req_valid  request present
//   req_ready  responder idle and able to accept a request
//   req_we     1 = store, 0 = load
//   req_mode   B=000 H=001 W=010 UB=100 UH=101, anything else is an error
//   req_addr   byte address (low ADDR_WIDTH bits decoded, upper bits alias)
//   req_wdata  right-aligned store data
//   rsp_valid  one-cycle completion pulse
//   rsp_rdata  extended load data, 0 for stores and errors
//   rsp_err    invalid mode, qualified by rsp_valid
module dmem_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_mode,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);

    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam int WORDS = 1 << IDX_W;
    localparam bit HAS_WAIT = (LATENCY > 0);
    localparam logic [2:0] WAIT_INIT = 3'(HAS_WAIT ? LATENCY - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_ONE = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACC0,
        S_ACC1,
        S_RESP
    } state_t;

    state_t state, state_next;

    logic [DATA_WIDTH-1:0] mem [WORDS];

    logic                  we_q;
    logic [2:0]            mode_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rd_accum;
    logic [2:0]            wait_cnt;

    logic                  handshake;
    logic                  mode_valid;
    logic [7:0]            size_mask;
    logic [7:0]            lanes8;
    logic                  split;
    logic [IDX_W-1:0]      idx0;
    logic [IDX_W-1:0]      acc_idx;
    logic [3:0]            acc_lanes;
    logic [4:0]            sh0;
    logic [4:0]            sh1;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] rd_piece;
    logic [DATA_WIDTH-1:0] wr_word;
    logic [DATA_WIDTH-1:0] assembled;
    logic                  in_acc;
    logic                  enter_ok;
    logic                  enter_err;

    // Address bits above ADDR_WIDTH alias onto the same array.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[DATA_WIDTH-1:ADDR_WIDTH];

    function automatic logic mode_ok(input logic [2:0] m);
        case (m)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: mode_ok = 1'b1;
            default:                                 mode_ok = 1'b0;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] extend(input logic [DATA_WIDTH-1:0] v,
                                                     input logic [2:0] m);
        case (m)
            3'b000:  extend = {{24{v[7]}}, v[7:0]};
            3'b001:  extend = {{16{v[15]}}, v[15:0]};
            3'b100:  extend = {24'd0, v[7:0]};
            3'b101:  extend = {16'd0, v[15:0]};
            default: extend = v;
        endcase
    endfunction

    assign req_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign handshake = req_valid & req_ready;
    assign in_acc    = (state == S_ACC0) || (state == S_ACC1);

    // Lane decode of the latched request. The size mask shifted by the byte
    // offset spans two words: the low nibble is the ACC0 lanes, the high
    // nibble the ACC1 lanes, so any high bit means the access is split.
    always_comb begin
        mode_valid = mode_ok(mode_q);
        case (mode_q[1:0])
            2'b00:   size_mask = 8'h01;
            2'b01:   size_mask = 8'h03;
            2'b10:   size_mask = 8'h0F;
            default: size_mask = 8'h00;
        endcase
        lanes8    = size_mask << addr_q[1:0];
        split     = (lanes8[7:4] != 4'd0);
        idx0      = addr_q[ADDR_WIDTH-1:2];
        acc_idx   = (state == S_ACC1) ? idx0 + IDX_ONE : idx0;
        acc_lanes = (state == S_ACC1) ? lanes8[7:4] : lanes8[3:0];
    end

    // Byte alignment between request data and array words. sh1 is 32-8*offset
    // modulo 32, which is only used for split accesses where offset != 0.
    // After the ACC0 shift the top offset bytes are zero and after the ACC1
    // shift the low 4-offset bytes are zero, so OR-ing the beats assembles
    // the little-endian value.
    always_comb begin
        sh0     = {addr_q[1:0], 3'b000};
        sh1     = 5'd0 - sh0;
        rd_word = mem[acc_idx];
        if (state == S_ACC1) begin
            rd_piece  = rd_word << sh1;
            wr_word   = wdata_q >> sh1;
            assembled = rd_accum | rd_piece;
        end else begin
            rd_piece  = rd_word >> sh0;
            wr_word   = wdata_q << sh0;
            assembled = rd_piece;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (handshake) begin
                    if (HAS_WAIT)
                        state_next = S_WAIT;
                    else if (mode_ok(req_mode))
                        state_next = S_ACC0;
                    else
                        state_next = S_RESP;
                end
            end
            S_WAIT: begin
                if (wait_cnt == 3'd0)
                    state_next = mode_valid ? S_ACC0 : S_RESP;
            end
            S_ACC0:  state_next = split ? S_ACC1 : S_RESP;
            S_ACC1:  state_next = S_RESP;
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    assign enter_ok  = in_acc && (state_next == S_RESP);
    assign enter_err = ((state == S_IDLE) || (state == S_WAIT)) && (state_next == S_RESP);

    // Request capture, wait counting, load assembly and the response registers,
    // which hold their value between responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q      <= 1'b0;
            mode_q    <= 3'd0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_accum  <= '0;
            wait_cnt  <= 3'd0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (handshake) begin
                we_q     <= req_we;
                mode_q   <= req_mode;
                addr_q   <= req_addr[ADDR_WIDTH-1:0];
                wdata_q  <= req_wdata;
                wait_cnt <= WAIT_INIT;
            end
            if (state == S_WAIT && wait_cnt != 3'd0)
                wait_cnt <= wait_cnt - 3'd1;
            if (state == S_ACC0)
                rd_accum <= rd_piece;
            if (enter_ok) begin
                rsp_rdata <= we_q ? '0 : extend(assembled, mode_q);
                rsp_err   <= 1'b0;
            end
            if (enter_err) begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b1;
            end
        end
    end

    // The array is not reset. A reset cycle suppresses the write so an
    // abandoned ACC1 beat leaves only the ACC0 bytes written.
    always_ff @(posedge clk) begin
        if (!rst && we_q && in_acc) begin
            for (int j = 0; j < 4; j++) begin
                if (acc_lanes[j])
                    mem[acc_idx][8*j +: 8] <= wr_word[8*j +: 8];
            end
        end
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for CPU load/store requests arriving over a valid/ready request channel.
- Owns a word-organised data array and applies byte lanes from the access mode and address offset.
- Sign- or zero-extends load data and returns it on a one-cycle response pulse.
- Inserts programmable wait states and splits word-crossing (misaligned) accesses into two sequential word beats, so the core never needs alignment traps.

Parameters:
- DATA_WIDTH, 32, data/address bus width (only 32 supported).
- ADDR_WIDTH, 12, byte-address bits decoded; array = 2^(ADDR_WIDTH-2) words.
- LATENCY, 1, wait-state cycles inserted before the first beat (0..7).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder idle, can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_mode  in  3  LS_mode: B=000, H=001, W=010, UB=100, UH=101; others invalid.
- req_addr  in  DATA_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  one-cycle completion pulse (loads and stores).
- rsp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors.
- rsp_err  out  1  invalid mode, qualified by rsp_valid.

Behaviour:
- Reset: state IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter 0; req_ready=1 from the first cycle after reset release. Array contents are not reset.
- req_ready = (state==IDLE), combinational from state. Handshake = req_valid & req_ready at a rising edge; all req_* fields are latched then. Inputs are ignored outside IDLE.
- Address decode uses req_addr[ADDR_WIDTH-1:0]; higher bits alias. Word index = addr[ADDR_WIDTH-1:2], offset = addr[1:0].
- Size: B/UB=1, H/UH=2, W=4 bytes. Access is split when offset+size > 4.
- States:
  - IDLE: on handshake -> WAIT if LATENCY>0 (counter loaded with LATENCY-1), else ACC0.
  - WAIT: counter decrements; at 0 -> ACC0.
  - ACC0: accesses word index, lanes offset..min(offset+size,4)-1. If split -> ACC1, else RESP.
  - ACC1: accesses word (index+1) modulo array size, lanes 0..(offset+size-5). Word index wrap-around at the top of the array is required. -> RESP.
  - RESP: rsp_valid=1 for exactly this cycle -> IDLE. The response has no backpressure.
- Stores: byte k of the right-aligned wdata is written to memory byte address addr+k. Writes occur at the end of each ACC cycle for the enabled lanes only.
- Loads: bytes are assembled little-endian from ACC0/ACC1 reads (combinational array read). Extension is applied to the assembled value: B sign-extends bit 7, H sign-extends bit 15, UB/UH zero-extend, W is unchanged.
- Invalid mode: WAIT is still honoured; ACC0/ACC1 are skipped (no write); RESP with rsp_err=1 and rdata=0.
- Timing, with handshake at edge T:
  - Aligned access: rsp_valid high in the cycle after edge T+1+LATENCY.
  - Split access: one cycle later than aligned.
  - Back-to-back throughput: one request per (LATENCY+3) cycles aligned.
- rsp_rdata and rsp_err are registered and hold their values until the next RESP or reset. rsp_valid is 0 outside RESP.
- Reset mid-operation: transaction abandoned, no response issued. For a split store reset in ACC1, the ACC0 beat remains written (partial write is permitted and defined).
- Read during the same cycle as a write to the same lane returns old data; this cannot occur within one transaction.

Test Plan:
1. Reset, LATENCY=1: rsp_valid=0, rsp_rdata=0, req_ready=1. Then SW 0x8899AABB @0x100, LW @0x100 -> rdata 0x8899AABB; each rsp_valid exactly 3 cycles after its handshake.
2. SB 0xF0 @0x101, then LB @0x101 -> 0xFFFFFFF0; LBU @0x101 -> 0x000000F0; LW @0x100 -> 0x8899F0BB.
3. SW 0x11223344 @0x200, SW 0x55667788 @0x204, then LW @0x202 -> 0x77881122 with two ACC beats (response one cycle later). LH @0x203 -> 0xFFFF8811.
4. SH 0xBEEF @0xFFF (ADDR_WIDTH=12) -> byte 0xFFF=0xEF, byte 0x000=0xBE via wrap. LHU @0xFFF -> 0x0000BEEF.
5. Invalid mode 3'b111 store @0x100 -> rsp_err=1, rdata=0, LW @0x100 unchanged. Then a valid load -> rsp_err=0.
6. Assert rst during WAIT of a store -> no rsp_valid, memory unchanged, req_ready=1 after release. Assert req_valid while busy -> ignored (no second response); LATENCY=0 aligned load responds 2 cycles after handshake.
